// File: rtl/serial_to_parallel_if.sv
// Host-side serial frame link into the MRAM write deserializer.
// The master drives the serial frame; the slave returns the assembled word.
interface serial_to_parallel_if #(
    parameter int BUS_WIDTH = 16
);
    logic                 en;
    logic                 start;
    logic [1:0]           word_sel;
    logic                 serial_in;
    logic [BUS_WIDTH-1:0] data_out;
    logic [1:0]           byte_en;
    logic                 data_valid;
    logic                 busy;
    logic                 frame_err;

    modport master (
        output en, start, word_sel, serial_in,
        input  data_out, byte_en, data_valid, busy, frame_err
    );

    modport slave (
        input  en, start, word_sel, serial_in,
        output data_out, byte_en, data_valid, busy, frame_err
    );
endinterface

// File: rtl/serial_to_parallel.sv
// Write-path deserializer: assembles an LSB-first word/byte frame into an
// aligned MRAM word with byte enables and a one-cycle valid strobe.
module serial_to_parallel #(
    parameter int BUS_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_to_parallel_if.slave   bus
);
    localparam int CW   = $clog2(BUS_WIDTH) + 1;
    localparam int IW   = $clog2(BUS_WIDTH);
    localparam int HALF = BUS_WIDTH / 2;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [BUS_WIDTH-1:0] asm_q;
    logic [1:0]           sel_q;

    logic [CW-1:0]        pos;
    logic [IW-1:0]        pos_idx;
    logic [CW-1:0]        frame_len;
    logic                 last_bit;
    logic [BUS_WIDTH-1:0] asm_nxt;

    // Upper-byte frames land at the top half; everything else starts at bit 0.
    always_comb begin
        pos       = (sel_q == 2'b10) ? (CW'(HALF) + cnt) : cnt;
        pos_idx   = pos[IW-1:0];
        frame_len = (sel_q == 2'b11) ? CW'(BUS_WIDTH) : CW'(HALF);
        last_bit  = (cnt == frame_len - CW'(1));
        asm_nxt   = asm_q;
        asm_nxt[pos_idx] = bus.serial_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            asm_q          <= '0;
            sel_q          <= 2'b00;
            bus.data_out   <= '0;
            bus.byte_en    <= 2'b00;
            bus.data_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.frame_err  <= 1'b0;
        end else if (bus.en) begin
            bus.data_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
            case (state)
                IDLE, COMMIT: begin
                    if (bus.start && bus.word_sel != 2'b00) begin
                        sel_q    <= bus.word_sel;
                        cnt      <= '0;
                        asm_q    <= '0;
                        state    <= SHIFT;
                        bus.busy <= 1'b1;
                    end else begin
                        bus.frame_err <= bus.start;
                        state         <= IDLE;
                        bus.busy      <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bus.start) begin
                        // Abort: partial word is dropped, outputs keep the last good frame.
                        bus.frame_err <= 1'b1;
                        if (bus.word_sel != 2'b00) begin
                            sel_q <= bus.word_sel;
                            cnt   <= '0;
                            asm_q <= '0;
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end else begin
                        asm_q <= asm_nxt;
                        cnt   <= cnt + CW'(1);
                        if (last_bit) begin
                            bus.data_out   <= asm_nxt;
                            bus.byte_en    <= sel_q;
                            bus.data_valid <= 1'b1;
                            bus.busy       <= 1'b0;
                            state          <= COMMIT;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel: frames, stalls, aborts and reset.
module tb_serial_to_parallel;
    localparam int BW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   dv_seen = 0;
    int   busy_seen = 0;

    always #5 clk = ~clk;

    serial_to_parallel_if #(.BUS_WIDTH(BW)) bus ();
    serial_to_parallel #(.BUS_WIDTH(BW)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start cycle drives serial_in=1 so a wrongly sampled start bit shows up.
    task automatic start_frame(input logic [1:0] ws);
        bus.en = 1'b1; bus.start = 1'b1; bus.word_sel = ws; bus.serial_in = 1'b1;
        tick();
        bus.start = 1'b0; bus.word_sel = 2'b00;
        busy_seen = int'(bus.busy);
    endtask

    task automatic send_range(input logic [15:0] d, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.en = 1'b1; bus.serial_in = d[i];
            tick();
            if (bus.data_valid) dv_seen++;
            if (bus.busy) busy_seen++;
        end
    endtask

    task automatic check_outs(input string tag, input logic [15:0] d, input logic [1:0] be);
        chk({tag, "_data"}, 32'(bus.data_out), 32'(d));
        chk({tag, "_be"}, 32'(bus.byte_en), 32'(be));
        chk({tag, "_dv"}, 32'(bus.data_valid), 32'd1);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.en = 1'b0; bus.start = 1'b0; bus.word_sel = 2'b00; bus.serial_in = 1'b0;
        #12;
        chk("rst_data", 32'(bus.data_out), 32'd0);
        chk("rst_be", 32'(bus.byte_en), 32'd0);
        chk("rst_flags", {29'd0, bus.data_valid, bus.busy, bus.frame_err}, 32'd0);
        rst = 1'b0;
        tick();

        // Full word, 16-cycle busy window
        dv_seen = 0;
        start_frame(2'b11);
        chk("fw_busy_start", 32'(bus.busy), 32'd1);
        send_range(16'hA5C3, 0, 15);
        check_outs("fw", 16'hA5C3, 2'b11);
        chk("fw_busy_cycles", 32'(busy_seen), 32'd16);
        chk("fw_dv_count", 32'(dv_seen), 32'd1);
        tick();
        chk("fw_dv_pulse", 32'(bus.data_valid), 32'd0);

        // Lower byte, then data_valid held across an en-low stall
        dv_seen = 0;
        start_frame(2'b01);
        send_range(16'h003C, 0, 7);
        check_outs("lb", 16'h003C, 2'b01);
        bus.en = 1'b0;
        tick(); tick();
        chk("lb_dv_hold", 32'(bus.data_valid), 32'd1);
        bus.en = 1'b1;
        tick();
        chk("lb_dv_drop", 32'(bus.data_valid), 32'd0);

        // Upper byte, then back-to-back lower byte started in COMMIT
        dv_seen = 0;
        start_frame(2'b10);
        send_range(16'h0081, 0, 7);
        check_outs("ub", 16'h8100, 2'b10);
        start_frame(2'b01);
        chk("b2b_dv", 32'(bus.data_valid), 32'd0);
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        send_range(16'h005A, 0, 7);
        check_outs("b2b", 16'h005A, 2'b01);
        chk("b2b_dv_count", 32'(dv_seen), 32'd2);
        tick();

        // en stall after bit 5; junk on inputs must be ignored
        dv_seen = 0;
        start_frame(2'b11);
        send_range(16'h1234, 0, 5);
        bus.en = 1'b0; bus.start = 1'b1; bus.word_sel = 2'b00; bus.serial_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_busy", 32'(bus.busy), 32'd1);
            chk("stall_flags", {30'd0, bus.data_valid, bus.frame_err}, 32'd0);
            chk("stall_data", 32'(bus.data_out), 32'h005A);
        end
        bus.start = 1'b0;
        send_range(16'h1234, 6, 14);
        chk("stall_no_early_dv", 32'(bus.data_valid), 32'd0);
        send_range(16'h1234, 15, 15);
        check_outs("stall", 16'h1234, 2'b11);
        tick();

        // Illegal start
        bus.start = 1'b1; bus.word_sel = 2'b00;
        tick();
        bus.start = 1'b0;
        chk("ill_err", 32'(bus.frame_err), 32'd1);
        chk("ill_busy", 32'(bus.busy), 32'd0);
        chk("ill_data", 32'(bus.data_out), 32'h1234);
        tick();
        chk("ill_err_pulse", 32'(bus.frame_err), 32'd0);

        // Abort after 5 bits, restart with full 0xFFFF
        dv_seen = 0;
        start_frame(2'b11);
        send_range(16'h0015, 0, 4);
        start_frame(2'b11);
        chk("abort_err", 32'(bus.frame_err), 32'd1);
        chk("abort_busy", 32'(bus.busy), 32'd1);
        chk("abort_dv", 32'(bus.data_valid), 32'd0);
        chk("abort_data", 32'(bus.data_out), 32'h1234);
        send_range(16'hFFFF, 0, 0);
        chk("abort_err_pulse", 32'(bus.frame_err), 32'd0);
        send_range(16'hFFFF, 1, 15);
        check_outs("abort", 16'hFFFF, 2'b11);
        chk("abort_dv_count", 32'(dv_seen), 32'd1);
        tick();

        // Reset mid-frame after 7 bits
        dv_seen = 0;
        start_frame(2'b11);
        send_range(16'h0F0F, 0, 6);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_data", 32'(bus.data_out), 32'd0);
        chk("mid_rst_be", 32'(bus.byte_en), 32'd0);
        chk("mid_rst_flags", {29'd0, bus.data_valid, bus.busy, bus.frame_err}, 32'd0);
        chk("mid_rst_dv_count", 32'(dv_seen), 32'd0);
        #1 rst = 1'b0;
        tick();
        start_frame(2'b01);
        send_range(16'h00AA, 0, 7);
        check_outs("post_rst", 16'h00AA, 2'b01);
        chk("post_rst_dv_count", 32'(dv_seen), 32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
- Write-path deserializer sitting between the host serial link and the MRAM write interface; mirror of the read-path parallel-to-serial stage.
- Accepts an LSB-first serial frame of a full word, lower byte or upper byte, selected by word_sel.
- Assembles the frame into an aligned BUS_WIDTH word plus byte enables and presents it to the MRAM write controller with a one-cycle valid strobe.

Parameters:
- BUS_WIDTH, 16, MRAM data word width; must be even and at least 4.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  clock enable; when low, all state, counters and outputs hold (a data_valid or frame_err pulse in progress also holds).
- start  input  1  frame start pulse; qualified by en.
- word_sel  input  2  sampled with start: 11 = full word, 01 = lower byte, 10 = upper byte, 00 = illegal.
- serial_in  input  1  serial data, LSB first, sampled on en cycles in SHIFT.
- data_out  output  BUS_WIDTH  assembled, aligned word; held until the next successful frame.
- byte_en  output  2  byte enables for data_out (copy of the frame's word_sel); held with data_out.
- data_valid  output  1  one-cycle pulse marking a new data_out/byte_en.
- busy  output  1  high while in SHIFT.
- frame_err  output  1  one-cycle pulse on an illegal start or an aborted frame.

Behaviour:
- Reset (async): state=IDLE, bit counter=0, shift/assembly register=0, data_out=0, byte_en=00, data_valid=0, busy=0, frame_err=0.
- Internal bit counter width is $clog2(BUS_WIDTH)+1. Frame length N = BUS_WIDTH for word_sel 11, and BUS_WIDTH/2 for 01 or 10.
- States are IDLE, SHIFT and COMMIT. Every transition below requires en=1.
- IDLE:
  - start with legal word_sel: latch word_sel, clear counter and assembly register, go to SHIFT.
  - start with word_sel=00: pulse frame_err and stay in IDLE.
  - The start cycle never samples serial_in.
- SHIFT:
  - Each en cycle samples serial_in as bit k (k=0 first) and increments the counter.
  - For word_sel 11 or 01, bit k goes to assembly[k]. For word_sel 10, bit k goes to assembly[BUS_WIDTH/2+k].
  - Positions that are not written read as 0.
  - When bit k=N-1 is sampled, go to COMMIT.
- SHIFT to COMMIT register update, on the same edge:
  - data_out <= assembly including the final bit.
  - byte_en <= latched word_sel.
  - data_valid <= 1.
- COMMIT:
  - Lasts one en cycle with data_valid high, then returns to IDLE.
  - A start in COMMIT is handled exactly as in IDLE (back-to-back frames allowed), and data_valid still pulses only one cycle.
- Latency: start on en-cycle 0, bits on en-cycles 1..N, data_valid high on en-cycle N+1.
- A start in SHIFT (abort/restart):
  - Pulse frame_err, discard the partial word (no data_valid) and leave data_out/byte_en unchanged.
  - With a legal word_sel: latch it, clear the counter and stay in SHIFT; that cycle does not sample serial_in.
  - With word_sel=00: go to IDLE.
- word_sel changes outside a start cycle are ignored.
- busy is high in SHIFT only, including the cycle the last bit is sampled; it is low in COMMIT.
- Reset mid-frame: immediate return to the reset values; the partial frame is lost with no pulse.

Test Plan:
- Full word: start with word_sel=11, then 0xA5C3 sent LSB first over 16 cycles -> data_out=0xA5C3, byte_en=11, data_valid high 17 cycles after start for exactly 1 cycle, busy high for 16 cycles.
- Lower byte: word_sel=01, serial 0x3C -> data_out=0x003C, byte_en=01, data_valid 9 cycles after start.
- Upper byte: word_sel=10, serial 0x81 -> data_out=0x8100, byte_en=10; then a back-to-back start in COMMIT with a 0x5A lower byte -> data_out=0x005A 9 cycles later.
- en stall: full word 0x1234 with en low for 3 cycles after bit 5 -> data_out=0x1234, data_valid delayed by exactly 3 cycles, all outputs frozen during the stall.
- Errors:
  - start with word_sel=00 -> frame_err 1 cycle, busy stays 0, data_out unchanged.
  - start in SHIFT after 5 bits, then a full 0xFFFF frame -> frame_err 1 cycle, a single data_valid with data_out=0xFFFF.
- Reset mid-frame: assert rst after 7 bits -> all outputs 0 immediately, no data_valid; the next frame of 0x00AA with word_sel=01 completes correctly.
